uart_char_tx: RTL
=================

# uart_char_tx

Byte-stream sink that buffers ASCII characters and serialises them onto a UART line (8N1, LSB first). It sits directly downstream of the number-to-character stage. That stage emits a burst of up to 10 digit characters on consecutive cycles with a valid strobe and no backpressure. This block absorbs the burst in a FIFO and drives the board TX pin at the configured bit rate.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2
- FIFO_DEPTH, 16, character buffer depth; power of two, minimum 2
- CLK  input  1  single system clock, rising edge
- RST  input  1  asynchronous, active-low reset
- char  input  8  character byte, sampled when valid_i is high
- valid_i  input  1  write strobe, one byte per cycle; no ready/backpressure
- txd  output  1  UART serial output, idle high
- busy  output  1  high while FIFO is non-empty or a frame is in progress
- drop_o  output  1  one-cycle pulse when a byte is discarded because the FIFO is full
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- **Write path:** on a rising edge with valid_i=1, char is pushed if occupancy < FIFO_DEPTH (the value before this edge's pop). Otherwise the byte is discarded and drop_o=1 for the following cycle. A full FIFO does not accept a write in the same cycle as a pop.
- **TX FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** txd=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, and go to START.
- **START:** txd=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** txd = shift[0]; shift right after each bit period. After 8 bit periods, go to STOP.
- **STOP:** txd=1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START, so there is no idle gap. Otherwise go to IDLE.
- **Counters:** the baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter is 3 bits. FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- **Simultaneous push and pop** with occupancy in 1..FIFO_DEPTH-1: level unchanged, both operations take effect.
- **busy** = (state != IDLE) || (level != 0), registered consistently with state and level.

## Timing
- **Reset values:** txd=1, busy=0, drop_o=0, level=0, state=IDLE, pointers=0. Reset mid-frame returns txd high immediately (asynchronously) and empties the FIFO. The partial frame is abandoned.
- **Latency:** byte sampled at edge k into an empty FIFO in IDLE → pop and txd falling at edge k+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- **level:** updates on the edge after the push or pop takes effect.
- **drop_o:** asserted for exactly one cycle per discarded byte.
- **Throughput:** sustained input rate must not exceed one byte per 10·CLKS_PER_BIT cycles. A burst of at most FIFO_DEPTH+1 bytes is lossless from IDLE, because the first byte is popped one cycle after it is written.

## Structure
- **Shared package:** TX state encoding (2-bit localparams), 8N1 frame constants (start=0, stop=1, data bits=8), default CLKS_PER_BIT.
- **Sub-module char_fifo:** synchronous single-clock FIFO with parameter DEPTH and ports CLK, RST, wr_en, wr_data, rd_en, rd_data, full, empty, level. It provides first-word fall-through read data.
- **Top level:** the TX FSM, baud counter, bit counter, shift register, and drop logic.

## Test plan (CLKS_PER_BIT=4, FIFO_DEPTH=16)
- **Reset:** hold RST low → txd=1, busy=0, level=0, drop_o=0.
- **Single byte:** char 0x35 ('5') at edge k → txd low from edge k+1 for 4 cycles. Then bits 1,0,1,0,1,1,0,0 for 4 cycles each, then high for 4 cycles. busy falls after 40 cycles and level returns to 0.
- **Ten-digit burst:** "0004294967" on 10 consecutive cycles → 10 contiguous frames totalling 400 cycles. Decoded bytes match in order, with no drop_o.
- **Overflow:** 20 consecutive bytes 0x41..0x54 → level peaks at 16 and drop_o pulses 3 times (bytes 0x52..0x54). The 17 bytes 0x41..0x51 are transmitted in order.
- **Reset mid-frame:** assert RST during DATA of the 2nd of 5 queued bytes → txd=1 immediately and level=0. After release, txd stays idle with no residual frames.
- **Push during STOP:** write 1 byte on the last STOP cycle of the previous frame → next START begins at the next edge, with no idle gap.

Source files
------------

// File: rtl/uart_char_tx_pkg.sv
// Shared definitions for the UART character transmitter: TX state encoding,
// 8N1 frame constants and the default bit period.
package uart_char_tx_pkg;

  typedef logic [7:0] char_t;
  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 2'd0;
  localparam tx_state_t ST_START = 2'd1;
  localparam tx_state_t ST_DATA  = 2'd2;
  localparam tx_state_t ST_STOP  = 2'd3;

  localparam logic        FRAME_START_BIT = 1'b0;
  localparam logic        FRAME_STOP_BIT  = 1'b1;
  localparam int unsigned FRAME_DATA_BITS = 8;

  // 100 MHz system clock, 115200 baud.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage : uart_char_tx_pkg

// File: rtl/uart_char_tx_if.sv
// Character write stream into the transmitter: one byte per cycle, no backpressure.
interface uart_char_tx_if;
  import uart_char_tx_pkg::*;

  char_t char;
  logic  valid_i;

  modport master (output char, output valid_i);
  modport slave  (input  char, input  valid_i);

endinterface : uart_char_tx_if

// File: rtl/uart_char_tx_char_fifo.sv
// Single-clock first-word fall-through character FIFO; rd_data shows the head
// whenever empty is low.
module char_fifo
  import uart_char_tx_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  char_t         wr_data,
  input  logic          rd_en,
  output char_t         rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);

  char_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign full    = (count_q == FULL_LEVEL);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // A full FIFO refuses a write even when a pop happens on the same edge.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule : char_fifo

// File: rtl/uart_char_tx.sv
// Buffered 8N1 UART transmitter: absorbs character bursts in a FIFO and
// serialises them LSB first, chaining frames with no idle gap.
module uart_char_tx
  import uart_char_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  uart_char_tx_if.slave                 in_if,
  output logic                          txd,
  output logic                          busy,
  output logic                          drop_o,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned      BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(FRAME_DATA_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  char_t             shift_q, shift_d;
  logic              drop_q, drop_d;

  logic  pop;
  logic  fifo_full, fifo_empty;
  char_t fifo_head;
  logic  baud_end;

  char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (in_if.valid_i),
    .wr_data (in_if.char),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign drop_d   = in_if.valid_i & fifo_full;
  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Chaining straight into START keeps back-to-back frames contiguous.
        if (baud_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            bit_d   = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // txd follows the registered state, so reset forces the line idle immediately.
  always_comb begin
    txd = FRAME_STOP_BIT;
    case (state_q)
      ST_START: txd = FRAME_START_BIT;
      ST_DATA:  txd = shift_q[0];
      default:  txd = FRAME_STOP_BIT;
    endcase
  end

  assign busy   = (state_q != ST_IDLE) || (level != '0);
  assign drop_o = drop_q;

endmodule : uart_char_tx
